nco_freq_meter: RTL and testbench

//   Gated frequency counter: the measuring end of the NCO path. It counts rising edges of
//   an asynchronous input (e.g. NCO output MSB routed back to a pin) over a fixed gate of

---
 rtl/nco_pkg.sv | 13 +
 rtl/sync_rise_det.sv | 26 ++
 rtl/nco_freq_meter.sv | 108 ++++++++++
 tb/tb_nco_freq_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// Shared constants and gate FSM states for the NCO measurement path.
package nco_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } meter_state_e;

  localparam int unsigned DEF_GATE_CYCLES = 27000000;
  localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge detector.
module sync_rise_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic in_clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], d_async};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule

// File: rtl/nco_freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a fixed gate.
module nco_freq_meter
  import nco_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             overflow
);

  localparam int unsigned      TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  meter_state_e     state_q;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             busy_q, valid_q, ovf_q;
  logic [CNT_W-1:0] result_q;
  logic             rise;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .in_clk (in_clk),
    .rst_n  (rst_n),
    .d_async(sig_in),
    .rise   (rise)
  );

  // Saturating edge count; sat records an edge that arrived with the counter full.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (rise) begin
      if (&cnt_q) sat_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= GATE;
            timer_q <= TMR_LOAD;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        GATE: begin
          cnt_q   <= cnt_d;
          sat_q   <= sat_d;
          timer_q <= timer_q - 1'b1;
          // Result registers load on entry to DONE so they are visible during the DONE cycle.
          if (timer_q == '0) begin
            state_q  <= DONE;
            result_q <= cnt_d;
            ovf_q    <= sat_d;
            valid_q  <= 1'b1;
          end
        end
        DONE: begin
          if (cont) begin
            state_q <= GATE;
            timer_q <= TMR_LOAD;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign count_out   = result_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_nco_freq_meter.sv
// Scoreboard bench: two meter instances (8-bit and 4-bit counters) share stimulus.
module tb_nco_freq_meter;
  localparam int G    = 100;
  localparam int SYNC = 2;

  logic       in_clk = 1'b0;
  logic       rst_n, sig_in, start, cont;
  logic       busy8, cv8, ov8, busy4, cv4, ov4;
  logic [7:0] co8;
  logic [3:0] co4;

  nco_freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .SYNC_STAGES(SYNC)) dut (
    .in_clk(in_clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy8), .count_out(co8), .count_valid(cv8), .overflow(ov8));

  nco_freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(SYNC)) dut_n (
    .in_clk(in_clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy4), .count_out(co4), .count_valid(cv4), .overflow(ov4));

  always #5 in_clk = ~in_clk;

  typedef struct {int t; int cnt; bit ovf;} exp_t;
  exp_t q8[$], q4[$];
  bit   wave [0:8191];
  int   cyc = 0;
  int   n_checks = 0, n_fail = 0;
  int   nv8 = 0, nv4 = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Pin value wave[n] is driven just after edge n.
  initial begin
    forever begin
      @(posedge in_clk);
      cyc++;
      #1 sig_in = wave[cyc];
    end
  end

  // A pin rise at cycle n is counted at edge n+SYNC+1; a gate started at edge s counts edges s+1..s+G.
  function automatic int exp_edges(int s);
    int c = 0;
    for (int n = s + 1 - (SYNC + 1); n <= s + G - (SYNC + 1); n++)
      if (wave[n] && !wave[n-1]) c++;
    return c;
  endfunction

  task automatic push_expect(input int s);
    exp_t e;
    int   n = exp_edges(s);
    e.t = s + G; e.cnt = (n > 255) ? 255 : n; e.ovf = (n > 255);
    q8.push_back(e);
    e.cnt = (n > 15) ? 15 : n; e.ovf = (n > 15);
    q4.push_back(e);
  endtask

  task automatic fill(input int from, input int to, input int mode, input int p);
    int ph = $urandom_range(0, p - 1);
    for (int n = from; n <= to; n++)
      case (mode)
        0:       wave[n] = 1'b0;
        1:       wave[n] = ((n + ph) % p) < (p / 2);
        default: wave[n] = 1'($urandom_range(0, 1));
      endcase
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((q8.size() != 0 || q4.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk("drain_pending", q8.size() + q4.size(), 0);
  endtask

  task automatic gate(input int mode, input int p);
    int s = cyc + 1;
    fill(cyc + 1, s + G + 5, mode, p);
    push_expect(s);
    pulse_start();
    chk("busy_after_start", int'(busy8 & busy4), 1);
    wait_drain(G + 10);
    step();
    chk("busy_idle", int'(busy8 | busy4), 0);
    repeat ($urandom_range(0, 7)) step();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge in_clk);
      if (cv8 === 1'b1) begin
        nv8++;
        if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
        else begin
          e = q8.pop_front();
          chk("valid_time8", cyc, e.t);
          chk("count8", int'(co8), e.cnt);
          chk("ovf8", int'(ov8), int'(e.ovf));
        end
      end
      if (cv4 === 1'b1) begin
        nv4++;
        if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
        else begin
          e = q4.pop_front();
          chk("valid_time4", cyc, e.t);
          chk("count4", int'(co4), e.cnt);
          chk("ovf4", int'(ov4), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int  s, nv_before;
    bit  dropped;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; sig_in = 1'b0;
    #1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_count", int'(co8), 0);
    chk("rst_valid", int'(cv8), 0);
    chk("rst_ovf", int'(ov8), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();

    gate(1, 10);          // period 10: 10 edges
    gate(0, 1);           // held low: 0 edges
    gate(1, 2);           // toggling: 50 edges, 4-bit copy saturates
    gate(1, 20);          // 5 edges: clears overflow
    repeat (4) gate(2, 2);

    // Second start mid-gate is dropped.
    s = cyc + 1;
    fill(cyc + 1, s + G + 5, 1, 8);
    push_expect(s);
    pulse_start();
    repeat (39) step();
    pulse_start();
    wait_drain(G + 10);
    nv_before = nv8;
    repeat (G + 10) step();
    chk("no_second_result", nv8 - nv_before, 0);

    // Continuous mode: three back-to-back gates, cont cleared during the third.
    s = cyc + 1;
    fill(cyc + 1, s + 3 * (G + 1) + 10, 1, 4);
    for (int k = 0; k < 3; k++) push_expect(s + k * (G + 1));
    cont = 1'b1;
    pulse_start();
    dropped = 1'b0;
    while (cyc < s + 2 * (G + 1) + 20) begin
      step();
      if (!busy8 || !busy4) dropped = 1'b1;
    end
    cont = 1'b0;
    chk("busy_held_cont", int'(dropped), 0);
    wait_drain(2 * G);
    step();
    chk("busy_after_cont", int'(busy8 | busy4), 0);

    // Reset mid-gate aborts the measurement.
    s = cyc + 1;
    fill(cyc + 1, s + G + 5, 1, 10);
    pulse_start();
    repeat (49) step();
    rst_n = 1'b0;
    fill(cyc + 1, cyc + G + 40, 0, 1);
    #1;
    chk("abort_busy", int'(busy8 | busy4), 0);
    chk("abort_count8", int'(co8), 0);
    chk("abort_count4", int'(co4), 0);
    chk("abort_valid", int'(cv8 | cv4), 0);
    chk("abort_ovf", int'(ov8 | ov4), 0);
    repeat (3) step();
    rst_n = 1'b1;
    nv_before = nv8 + nv4;
    repeat (G + 20) step();
    chk("no_valid_after_abort", nv8 + nv4 - nv_before, 0);
    gate(1, 10);

    repeat (5) step();
    chk("final_queue", q8.size() + q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
